dfp_align_ctrl: RTL and testbench
=================================

DFP_ALIGN_CTRL -- requirements
Module: dfp_align_ctrl

Interface
REQ-001 SHALL have parameter MAX_SHIFT, default 8, meaning the maximum digit shifts applied to the smaller-exponent mantissa (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the operand-pair handshake.
REQ-005 SHALL have inputs s1 (1), e1 (8), m1 (28) and s2 (1), e2 (8), m2 (28): converted sign, biased exponent and 7-digit BCD coefficient per operand.
REQ-006 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-007 SHALL have outputs out_e (8), out_sbig (1), out_mbig (32), out_ssmall (1), out_msmall (32), out_sticky (1) and out_swap (1): aligned result, with 32-bit mantissas being 7 digits plus 1 guard digit.

Function
REQ-008 SHALL implement states IDLE, ALIGN and DONE.
REQ-009 SHALL drive in_ready=1 only in IDLE, and accept an operand pair on an edge where in_valid and in_ready are both 1.
REQ-010 SHALL, on acceptance, set swap=(e2>e1), with equal exponents giving swap=0.
REQ-011 SHALL, on acceptance, load big={m_big,4'h0}, small={m_small,4'h0}, out_e=max(e1,e2), sticky=0 and cnt=min(|e1-e2|,MAX_SHIFT), with the subtraction done at 9-bit width.
REQ-012 SHALL go from IDLE to DONE on acceptance if cnt=0, otherwise to ALIGN.
REQ-013 SHALL, on each ALIGN edge, shift small right by one BCD digit (4 bits, zero fill), OR (shifted-out nibble!=0) into sticky, and decrement cnt.
REQ-014 SHALL go from ALIGN to DONE on the edge where cnt decrements to 0.
REQ-015 SHALL assert out_valid only in DONE, with out_valid rising min(|e1-e2|,MAX_SHIFT) edges after the accepting edge, or on that same edge when the count is 0.
REQ-016 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-017 SHALL go from DONE to IDLE on the edge where out_ready=1, with no new acceptance on that edge.
REQ-018 SHALL not modify out_mbig, out_sbig or out_e during ALIGN.
REQ-019 SHALL ignore in_valid outside IDLE, and input changes outside IDLE SHALL have no effect.
REQ-020 SHALL pass signs through unchanged, following swap.
REQ-021 SHALL, when |e1-e2|>=MAX_SHIFT=8, end with out_msmall=0 and out_sticky=(m_small!=0).

Reset
REQ-022 SHALL, while rst=1, force state=IDLE, in_ready=1, out_valid=0, cnt=0 and every data output to 0.
REQ-023 SHALL, on rst asserted mid-ALIGN or in DONE, abandon the pending result with no out_valid pulse.
REQ-024 SHALL accept a new pair on the first edge after rst deasserts if in_valid=1.

Configuration
REQ-025 SHALL, with macro DFP_ALIGN_EARLY_EXIT_EN defined, end alignment early when the small register is all-zero: IDLE goes straight to DONE when m_small=0, and ALIGN goes to DONE on any edge where small==0, without shifting.
REQ-026 SHALL, without DFP_ALIGN_EARLY_EXIT_EN, always perform exactly min(|e1-e2|,MAX_SHIFT) shifts; data outputs are identical in both builds and only latency differs.

Verification
REQ-027 SHALL cover: e1=101, m1=28'h1234567, e2=99, m2=28'h0000025 -> swap=0, out_e=101, out_mbig=32'h12345670, out_msmall=32'h00000002, sticky=1, out_valid 2 edges after accept.
REQ-028 SHALL cover: e1=e2=50, m1=28'h0000001, m2=28'h0000009 -> swap=0, out_msmall=32'h00000090, sticky=0, out_valid on the accepting edge.
REQ-029 SHALL cover: e1=90, m1=28'h0000001, e2=120, m2=28'h0000009 -> swap=1, out_e=120, out_msmall=0, sticky=1; latency 8 without macro, 3 with DFP_ALIGN_EARLY_EXIT_EN.
REQ-030 SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-031 SHALL cover: rst pulsed during ALIGN with cnt=4 -> all outputs 0 immediately, no out_valid, in_ready=1.
REQ-032 SHALL cover: in_valid held 1 continuously with out_ready=1 -> one acceptance per transaction, never during ALIGN or DONE.

Source files
------------

// File: rtl/dfp_align_ctrl.sv
// Decimal floating-point operand alignment controller.
// Takes a pair of unpacked DFP operands and swaps them so the larger exponent is
// "big". The smaller-exponent coefficient is then shifted right one BCD digit per
// cycle until the exponents match or MAX_SHIFT digits have been dropped. Any
// non-zero digit that falls off the end is collected into a sticky bit.
// Optional build macro: DFP_ALIGN_EARLY_EXIT_EN. It stops alignment as soon as the
// small register is all zero. Data results are unchanged; only latency shrinks.
module dfp_align_ctrl #(
  parameter int unsigned MAX_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        s1,
  input  logic [7:0]  e1,
  input  logic [27:0] m1,
  input  logic        s2,
  input  logic [7:0]  e2,
  input  logic [27:0] m2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_e,
  output logic        out_sbig,
  output logic [31:0] out_mbig,
  output logic        out_ssmall,
  output logic [31:0] out_msmall,
  output logic        out_sticky,
  output logic        out_swap
);

  localparam logic [8:0] MaxShiftW = 9'(MAX_SHIFT);
  localparam logic [3:0] MaxShiftC = 4'(MAX_SHIFT);

  typedef enum logic [1:0] {StIdle, StAlign, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  e_q, e_d;
  logic [31:0] big_q, big_d, small_q, small_d;
  logic        sbig_q, sbig_d, ssmall_q, ssmall_d;
  logic        sticky_q, sticky_d, swap_q, swap_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic        swap_in;
  logic [8:0]  diff_in;
  logic [3:0]  cnt_in;
  logic [27:0] msmall_in;
  logic        skip_align;

  // Operand-pair decode: order by exponent and clamp the digit distance.
  always_comb begin
    swap_in   = (e2 > e1);
    diff_in   = swap_in ? ({1'b0, e2} - {1'b0, e1}) : ({1'b0, e1} - {1'b0, e2});
    cnt_in    = (diff_in > MaxShiftW) ? MaxShiftC : diff_in[3:0];
    msmall_in = swap_in ? m1 : m2;
`ifdef DFP_ALIGN_EARLY_EXIT_EN
    skip_align = (cnt_in == 4'd0) || (msmall_in == 28'd0);
`else
    skip_align = (cnt_in == 4'd0);
`endif
  end

  // Next-state and datapath update for the IDLE -> ALIGN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    e_d      = e_q;
    big_d    = big_q;
    small_d  = small_q;
    sbig_d   = sbig_q;
    ssmall_d = ssmall_q;
    sticky_d = sticky_q;
    swap_d   = swap_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          swap_d   = swap_in;
          e_d      = swap_in ? e2 : e1;
          big_d    = {(swap_in ? m2 : m1), 4'h0};
          small_d  = {msmall_in, 4'h0};
          sbig_d   = swap_in ? s2 : s1;
          ssmall_d = swap_in ? s1 : s2;
          sticky_d = 1'b0;
          cnt_d    = cnt_in;
          state_d  = skip_align ? StDone : StAlign;
        end
      end
      StAlign: begin
`ifdef DFP_ALIGN_EARLY_EXIT_EN
        if (small_q == 32'd0) begin
          // Nothing left to shift out; further shifts cannot change the result.
          cnt_d   = 4'd0;
          state_d = StDone;
        end else
`endif
        begin
          small_d  = {4'h0, small_q[31:4]};
          sticky_d = sticky_q | (|small_q[3:0]);
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      e_q         <= 8'd0;
      big_q       <= 32'd0;
      small_q     <= 32'd0;
      sbig_q      <= 1'b0;
      ssmall_q    <= 1'b0;
      sticky_q    <= 1'b0;
      swap_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      e_q         <= e_d;
      big_q       <= big_d;
      small_q     <= small_d;
      sbig_q      <= sbig_d;
      ssmall_q    <= ssmall_d;
      sticky_q    <= sticky_d;
      swap_q      <= swap_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_e      = e_q;
  assign out_sbig   = sbig_q;
  assign out_mbig   = big_q;
  assign out_ssmall = ssmall_q;
  assign out_msmall = small_q;
  assign out_sticky = sticky_q;
  assign out_swap   = swap_q;

endmodule

// File: tb/tb_dfp_align_ctrl.sv
// Self-checking bench for dfp_align_ctrl: directed corner vectors followed by
// random operand pairs, compared against an arithmetic reference model.
module tb_dfp_align_ctrl;

  localparam int MaxShift = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        s1 = 1'b0, s2 = 1'b0;
  logic [7:0]  e1 = '0, e2 = '0;
  logic [27:0] m1 = '0, m2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_e;
  logic        out_sbig, out_ssmall, out_sticky, out_swap;
  logic [31:0] out_mbig, out_msmall;

  int n_checks = 0;
  int n_err    = 0;
  int n_acc    = 0;

  dfp_align_ctrl #(.MAX_SHIFT(MaxShift)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s1(s1), .e1(e1), .m1(m1), .s2(s2), .e2(e2), .m2(m2),
    .out_valid(out_valid), .out_ready(out_ready), .out_e(out_e),
    .out_sbig(out_sbig), .out_mbig(out_mbig), .out_ssmall(out_ssmall),
    .out_msmall(out_msmall), .out_sticky(out_sticky), .out_swap(out_swap)
  );

  always #5 clk = ~clk;

  // Count every handshake the DUT takes.
  always @(posedge clk) if (!rst && in_valid && in_ready) n_acc <= n_acc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] rand_bcd();
    logic [27:0] v;
    int nd;
    v  = '0;
    nd = $urandom_range(0, 7);
    for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 2) == 0) v = v << (4 * $urandom_range(1, 3));
    return v;
  endfunction

  task automatic run_txn(input logic a_s1, input logic [7:0] a_e1, input logic [27:0] a_m1,
                         input logic a_s2, input logic [7:0] a_e2, input logic [27:0] a_m2,
                         input bit hold, input int stall);
    logic        x_swap, x_sbig, x_ssmall, x_sticky;
    logic [7:0]  x_e;
    logic [31:0] x_big, x_small, sf;
    int          d, k, j0, x_lat, lat, acc0;
    // Reference: alignment is a plain right shift by k digits of the padded coefficient.
    x_swap   = (a_e2 > a_e1);
    x_e      = x_swap ? a_e2 : a_e1;
    d        = x_swap ? (int'(a_e2) - int'(a_e1)) : (int'(a_e1) - int'(a_e2));
    k        = (d < MaxShift) ? d : MaxShift;
    x_big    = {(x_swap ? a_m2 : a_m1), 4'h0};
    sf       = {(x_swap ? a_m1 : a_m2), 4'h0};
    x_small  = sf >> (4 * k);
    x_sticky = ((x_small << (4 * k)) != sf);
    x_sbig   = x_swap ? a_s2 : a_s1;
    x_ssmall = x_swap ? a_s1 : a_s2;
    x_lat    = k;
`ifdef DFP_ALIGN_EARLY_EXIT_EN
    j0 = 0;
    while (j0 < 8 && (sf >> (4 * j0)) != 0) j0++;
    if (sf == 0) x_lat = 0;
    else if (j0 < k) x_lat = j0 + 1;
`else
    j0 = 0;
`endif
    acc0      = n_acc;
    s1 = a_s1; e1 = a_e1; m1 = a_m1; s2 = a_s2; e2 = a_e2; m2 = a_m2;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); @(negedge clk);
    if (!hold) in_valid = 1'b0;
    // Scribble the operand inputs; the DUT must ignore them now.
    s1 = 1'($urandom); e1 = 8'($urandom); m1 = 28'($urandom);
    s2 = 1'($urandom); e2 = 8'($urandom); m2 = 28'($urandom);
    chk("accept_once", 32'(n_acc - acc0), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      chk("e_during_align", {24'd0, out_e}, {24'd0, x_e});
      chk("mbig_during_align", out_mbig, x_big);
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(x_lat));
    for (int c = 0; c <= stall; c++) begin
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("in_ready_done", {31'd0, in_ready}, 32'd0);
      chk("swap", {31'd0, out_swap}, {31'd0, x_swap});
      chk("out_e", {24'd0, out_e}, {24'd0, x_e});
      chk("mbig", out_mbig, x_big);
      chk("msmall", out_msmall, x_small);
      chk("sticky", {31'd0, out_sticky}, {31'd0, x_sticky});
      chk("signs", {30'd0, out_sbig, out_ssmall}, {30'd0, x_sbig, x_ssmall});
      if (c < stall) begin
        @(posedge clk); @(negedge clk);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    chk("no_accept_on_exit", 32'(n_acc - acc0), 32'd1);
  endtask

  initial begin
    int seen;
    // Reset state, with a pair already offered so it is taken on the first edge.
    s1 = 1'b0; e1 = 8'd101; m1 = 28'h1234567; s2 = 1'b1; e2 = 8'd99; m2 = 28'h0000025;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_mbig | out_msmall | {24'd0, out_e}, 32'd0);
    chk("rst_bits", {28'd0, out_sbig, out_ssmall, out_sticky, out_swap}, 32'd0);
    rst = 1'b0;

    run_txn(1'b0, 8'd101, 28'h1234567, 1'b1, 8'd99, 28'h0000025, 1'b0, 0);
    run_txn(1'b1, 8'd50, 28'h0000001, 1'b0, 8'd50, 28'h0000009, 1'b0, 0);
    run_txn(1'b0, 8'd90, 28'h0000001, 1'b1, 8'd120, 28'h0000009, 1'b0, 0);
    run_txn(1'b0, 8'd101, 28'h1234567, 1'b0, 8'd99, 28'h0000025, 1'b0, 5);
    run_txn(1'b1, 8'd10, 28'h0000000, 1'b0, 8'd14, 28'h9999999, 1'b0, 1);
    run_txn(1'b0, 8'd255, 28'h7654321, 1'b1, 8'd0, 28'h1000000, 1'b0, 0);

    // Reset while ALIGN holds cnt=4: result dropped, outputs cleared at once.
    s1 = 1'b1; e1 = 8'd100; m1 = 28'h1111111; s2 = 1'b1; e2 = 8'd96; m2 = 28'h2222222;
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", out_mbig | out_msmall | {24'd0, out_e}, 32'd0);
    chk("midrst_bits", {28'd0, out_sbig, out_ssmall, out_sticky, out_swap}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_pulse", 32'(seen), 32'd0);

    // in_valid held high across back-to-back transactions.
    for (int t = 0; t < 4; t++)
      run_txn(1'($urandom), 8'($urandom_range(40, 60)), rand_bcd(),
              1'($urandom), 8'($urandom_range(40, 60)), rand_bcd(), 1'b1, 0);
    in_valid = 1'b0;

    // Random pairs, exponents mostly close so partial shifts dominate.
    for (int t = 0; t < 30; t++) begin
      logic [7:0] ea, eb;
      ea = 8'($urandom);
      eb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(ea + $urandom_range(0, 20) - 10);
      run_txn(1'($urandom), ea, rand_bcd(), 1'($urandom), eb, rand_bcd(),
              1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
